line_window_buffer: RTL and testbench
=====================================

LINE_WINDOW_BUFFER -- requirements
Module: line_window_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the pixel width in bits.
REQ-002 SHALL have parameter IMG_WIDTH, default 640, the pixels per image row (legal range 2 to 4096).
REQ-003 SHALL have parameter ROWS, default 3, the window height and column length (legal range 2 to 8).
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1 bit, indicating the upstream pixel is valid.
REQ-007 SHALL have port in_ready, output, 1 bit, indicating the block accepts a pixel this cycle.
REQ-008 SHALL have port in_sof, input, 1 bit, start-of-frame, qualified by in_valid.
REQ-009 SHALL have port in_data, input, DATA_WIDTH bits, the raster-order pixel.
REQ-010 SHALL have port out_valid, output, 1 bit, indicating out_col is valid.
REQ-011 SHALL have port out_ready, input, 1 bit, the downstream accept signal; it drives the window shift register's shift_en together with out_valid.
REQ-012 SHALL have port out_col, output, ROWS x DATA_WIDTH bits; index 0 is the current row and index ROWS-1 is the oldest row.
REQ-013 SHALL have port out_win_valid, output, 1 bit, indicating a full ROWS x ROWS window exists downstream after this shift.
REQ-014 SHALL have port out_col_idx, output, clog2(IMG_WIDTH) bits, the column of out_col[0].
REQ-015 SHALL have port out_row_idx, output, 16 bits, the row of out_col[0] (saturating).

Function
REQ-016 SHALL implement a state machine with two states: IDLE (no frame) and ACTIVE.
REQ-017 SHALL, in IDLE, hold in_ready=1 and drop pixels with in_sof=0 without producing output.
REQ-018 SHALL transition IDLE->ACTIVE on an accepted pixel with in_sof=1; that pixel is row 0, column 0.
REQ-019 SHALL, in ACTIVE, treat any accepted in_sof=1 as a frame restart: counters reset to 0 and the pixel becomes row 0, column 0.
REQ-020 SHALL drive in_ready = !out_valid || out_ready, giving a one-entry output register.
REQ-021 SHALL update out_col, out_valid and the indices exactly 1 cycle after each accepted pixel, with no bubbles under continuous valid/ready.
REQ-022 SHALL hold all outputs stable while out_valid=1 and out_ready=0.
REQ-023 SHALL clear out_valid after out_valid && out_ready when no new pixel is accepted in the same cycle.
REQ-024 SHALL keep ROWS-1 line memories of IMG_WIDTH entries each, addressed by the column counter.
REQ-025 SHALL form out_col[k] from line memory k-1 read at the current column for k>=1, with out_col[0]=in_data.
REQ-026 SHALL, on each accepted pixel, shift the column down one line memory (write in_data into line 0, line k-1 into line k) at the current column.
REQ-027 SHALL increment the column counter per accepted pixel and wrap it from IMG_WIDTH-1 to 0, incrementing the row counter on wrap.
REQ-028 SHALL saturate the row counter at 65535.
REQ-029 SHALL assert out_win_valid when row >= ROWS-1 and col >= ROWS-1 for the emitted pixel, and deassert it otherwise, including on the first ROWS-1 columns of every row.
REQ-030 SHALL ensure that simultaneous accept and output handshake in the same cycle loses no data.

Reset
REQ-031 SHALL, on rst_n low, asynchronously force state IDLE, out_valid=0, out_col=0, out_win_valid=0, out_col_idx=0, out_row_idx=0, with counters at 0.
REQ-032 SHALL not reset line memory contents.
REQ-033 SHALL, when reset is asserted mid-frame, discard the frame; the next frame requires in_sof.
REQ-034 SHALL make in_ready=1 in the first cycle after reset is released.

Configuration
REQ-035 SHALL, with macro LINE_WINDOW_BUFFER_BORDER_ZERO_EN defined, force out_col[k]=0 whenever row < k, so no stale or previous-frame data appears.
REQ-036 SHALL, without LINE_WINDOW_BUFFER_BORDER_ZERO_EN, output raw line memory contents for row < k, and memory contents remain undefined after reset.

Verification (IMG_WIDTH=4, ROWS=3, DATA_WIDTH=8)
REQ-037 SHALL cover: stream pixels 1..12 with in_sof on pixel 1 and out_ready=1 -> at pixel 11 (row 2, col 2) out_col={11,7,3} and out_win_valid=1; pixels 1..10 give out_win_valid=0.
REQ-038 SHALL cover: send 3 pixels with in_sof=0 before in_sof -> no out_valid pulses; the first output has row=0, col=0.
REQ-039 SHALL cover: hold out_ready=0 for 5 cycles after the first output -> in_ready=0, outputs unchanged; on release the stream resumes with no loss or duplication.
REQ-040 SHALL cover: assert in_sof on pixel 7 mid-frame -> that output has row=0, col=0; with the macro defined out_col={p,0,0}.
REQ-041 SHALL cover: assert rst_n low during row 1 -> outputs are 0 asynchronously; after release a new frame of 12 pixels matches REQ-037.
REQ-042 SHALL cover: toggle in_valid randomly over 2 frames -> out_col order matches the reference raster model exactly.

Source files
------------

// File: rtl/line_window_buffer.sv
// Raster pixel stream -> ROWS-tall column per accepted pixel, backed by ROWS-1 line memories.
// Optional build macro LINE_WINDOW_BUFFER_BORDER_ZERO_EN zeroes column taps above the frame top.
module line_window_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int ROWS       = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic                                in_sof,
  input  logic [DATA_WIDTH-1:0]               in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [ROWS-1:0][DATA_WIDTH-1:0]     out_col,
  output logic                                out_win_valid,
  output logic [$clog2(IMG_WIDTH)-1:0]        out_col_idx,
  output logic [15:0]                         out_row_idx
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [31:0] WIN_MIN = 32'(ROWS - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                          state_r, state_n;
  logic [CW-1:0]                   col_r, col_s, col_n;
  logic [15:0]                     row_r, row_s, row_n;
  logic                            accept_s, take_s, win_s, out_valid_n;
  logic [ROWS-1:0][DATA_WIDTH-1:0] col_data_s;
  logic [DATA_WIDTH-1:0]           mem_r [ROWS-1][IMG_WIDTH];

  logic                            out_valid_r, out_win_valid_r;
  logic [ROWS-1:0][DATA_WIDTH-1:0] out_col_r;
  logic [CW-1:0]                   out_col_idx_r;
  logic [15:0]                     out_row_idx_r;

  assign in_ready      = !out_valid_r || out_ready;
  assign out_valid     = out_valid_r;
  assign out_col       = out_col_r;
  assign out_win_valid = out_win_valid_r;
  assign out_col_idx   = out_col_idx_r;
  assign out_row_idx   = out_row_idx_r;

  // Handshake, frame FSM, pixel position, column assembly and output-valid next value
  always_comb begin
    accept_s = in_valid && in_ready;
    take_s   = accept_s && (in_sof || (state_r == ACTIVE));
    // A start-of-frame pixel is always placed at row 0, column 0
    col_s    = in_sof ? {CW{1'b0}} : col_r;
    row_s    = in_sof ? 16'd0 : row_r;
    state_n  = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && in_sof) begin
          state_n = ACTIVE;
        end else begin
          state_n = IDLE;
        end
      end
      ACTIVE:  state_n = ACTIVE;
      default: state_n = IDLE;
    endcase
    if (col_s == COL_LAST) begin
      col_n = {CW{1'b0}};
      if (row_s == 16'hFFFF) begin
        row_n = row_s;
      end else begin
        row_n = row_s + 16'd1;
      end
    end else begin
      col_n = col_s + CW'(1'b1);
      row_n = row_s;
    end
    win_s = (32'(row_s) >= WIN_MIN) && (32'(col_s) >= WIN_MIN);
    col_data_s    = {ROWS{{DATA_WIDTH{1'b0}}}};
    col_data_s[0] = in_data;
    for (int k = 1; k < ROWS; k++) begin
`ifdef LINE_WINDOW_BUFFER_BORDER_ZERO_EN
      if (32'(row_s) < 32'(k)) begin
        col_data_s[k] = {DATA_WIDTH{1'b0}};
      end else begin
        col_data_s[k] = mem_r[k-1][col_s];
      end
`else
      col_data_s[k] = mem_r[k-1][col_s];
`endif
    end
    if (take_s) begin
      out_valid_n = 1'b1;
    end else if (out_ready) begin
      out_valid_n = 1'b0;
    end else begin
      out_valid_n = out_valid_r;
    end
  end

  // FSM, position counters and the one-entry output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= IDLE;
      col_r           <= {CW{1'b0}};
      row_r           <= 16'd0;
      out_valid_r     <= 1'b0;
      out_win_valid_r <= 1'b0;
      out_col_r       <= {ROWS{{DATA_WIDTH{1'b0}}}};
      out_col_idx_r   <= {CW{1'b0}};
      out_row_idx_r   <= 16'd0;
    end else begin
      state_r     <= state_n;
      out_valid_r <= out_valid_n;
      if (take_s) begin
        col_r           <= col_n;
        row_r           <= row_n;
        out_col_r       <= col_data_s;
        out_win_valid_r <= win_s;
        out_col_idx_r   <= col_s;
        out_row_idx_r   <= row_s;
      end
    end
  end

  // Line memories: contents survive reset; each accepted pixel pushes its column one line deeper
  always_ff @(posedge clk) begin
    if (take_s) begin
      for (int k = 0; k < ROWS - 1; k++) begin
        if (k == 0) begin
          mem_r[0][col_s] <= in_data;
        end else begin
          mem_r[k][col_s] <= mem_r[k-1][col_s];
        end
      end
    end
  end
endmodule

// File: tb/tb_line_window_buffer.sv
// Bench for line_window_buffer: directed vector table, corner sequences and a randomized
// stream checked against a per-column history model (IMG_WIDTH=4, ROWS=3, DATA_WIDTH=8).
module tb_line_window_buffer;
  localparam int DW = 8;
  localparam int IW = 4;
  localparam int RW = 3;
`ifdef LINE_WINDOW_BUFFER_BORDER_ZERO_EN
  localparam bit BZ = 1'b1;
`else
  localparam bit BZ = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n, in_valid, in_ready, in_sof, out_valid, out_ready, out_win_valid;
  logic [DW-1:0]        in_data;
  logic [RW-1:0][DW-1:0] out_col;
  logic [1:0]           out_col_idx;
  logic [15:0]          out_row_idx;

  int checks = 0;
  int failures = 0;

  line_window_buffer #(.DATA_WIDTH(DW), .IMG_WIDTH(IW), .ROWS(RW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col),
    .out_win_valid(out_win_valid), .out_col_idx(out_col_idx), .out_row_idx(out_row_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0][7:0] c;
    logic [2:0]      kn;
    bit              win;
    int              ri;
    int              ci;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    bit         sof;
    int         ri;
    int         ci;
    logic [7:0] c1;
    logic [7:0] c2;
    bit         win;
  } vec_t;

  vec_t tbl [12];
  exp_t q [$];
  int   hist [IW][$];
  bit   m_active = 1'b0;
  int   m_pix = 0;
  bit   prev_stall = 1'b0;
  logic [23:0] snap_col;
  bit   snap_win;
  int   snap_ci, snap_ri;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: pixel index since SOF gives row/col; each column keeps its own history of pixels
  task automatic model_accept(input bit sof, input logic [7:0] d);
    exp_t e;
    int row, col;
    if (sof) begin
      m_active = 1'b1;
      m_pix = 0;
    end
    if (m_active) begin
      row = m_pix / IW;
      if (row > 65535) row = 65535;
      col = m_pix % IW;
      e.ri = row;
      e.ci = col;
      e.win = (row >= RW - 1) && (col >= RW - 1);
      e.c = 24'd0;
      e.kn = 3'b001;
      e.c[0] = d;
      for (int k = 1; k < RW; k++) begin
        if (BZ && row < k) begin
          e.c[k] = 8'd0;
          e.kn[k] = 1'b1;
        end else if (hist[col].size() >= k) begin
          e.c[k] = 8'(hist[col][k-1]);
          e.kn[k] = 1'b1;
        end else begin
          e.kn[k] = 1'b0;
        end
      end
      hist[col].push_front(int'(d));
      q.push_back(e);
      m_pix++;
    end
  endtask

  task automatic step(input bit v, input bit sof, input logic [7:0] d, input bit ordy, output bit acc);
    exp_t e;
    @(negedge clk);
    in_valid = v; in_sof = sof; in_data = d; out_ready = ordy;
    #1;
    if (prev_stall) begin
      chk("hold_col", int'(out_col), int'(snap_col));
      chk("hold_win", int'(out_win_valid), int'(snap_win));
      chk("hold_idx", int'(out_row_idx) * 4 + int'(out_col_idx), snap_ri * 4 + snap_ci);
      chk("hold_valid", int'(out_valid), 1);
    end
    chk("in_ready_rule", int'(in_ready), int'(!out_valid || ordy));
    if (out_valid && ordy) begin
      if (q.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        e = q.pop_front();
        chk("sb_row", int'(out_row_idx), e.ri);
        chk("sb_col", int'(out_col_idx), e.ci);
        chk("sb_win", int'(out_win_valid), int'(e.win));
        for (int k = 0; k < RW; k++) begin
          if (e.kn[k]) chk($sformatf("sb_data%0d", k), int'(out_col[k]), int'(e.c[k]));
        end
      end
    end
    prev_stall = out_valid && !ordy;
    snap_col = out_col; snap_win = out_win_valid;
    snap_ci = int'(out_col_idx); snap_ri = int'(out_row_idx);
    acc = v && in_ready;
    if (acc) model_accept(sof, d);
  endtask

  task automatic send(input bit sof, input logic [7:0] d);
    bit acc;
    int n = 0;
    do begin
      step(1'b1, sof, d, 1'b1, acc);
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic drain_check(input string name);
    bit acc;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'd0, 1'b1, acc);
    chk(name, q.size(), 0);
  endtask

  task automatic reset_values(input string name);
    chk({name, "_valid"}, int'(out_valid), 0);
    chk({name, "_col"}, int'(out_col), 0);
    chk({name, "_win"}, int'(out_win_valid), 0);
    chk({name, "_idx"}, int'(out_row_idx) + int'(out_col_idx), 0);
  endtask

  task automatic run_table(input string tag);
    bit acc;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, tbl[i].sof, tbl[i].d, 1'b1, acc);
      chk({tag, "_accept"}, int'(acc), 1);
      @(posedge clk); #1;
      chk({tag, "_valid"}, int'(out_valid), 1);
      chk({tag, "_row"}, int'(out_row_idx), tbl[i].ri);
      chk({tag, "_colidx"}, int'(out_col_idx), tbl[i].ci);
      chk({tag, "_win"}, int'(out_win_valid), int'(tbl[i].win));
      chk({tag, "_c0"}, int'(out_col[0]), int'(tbl[i].d));
      if (BZ || tbl[i].ri >= 1) chk({tag, "_c1"}, int'(out_col[1]), int'(tbl[i].c1));
      if (BZ || tbl[i].ri >= 2) chk({tag, "_c2"}, int'(out_col[2]), int'(tbl[i].c2));
    end
    drain_check({tag, "_drain"});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int fp;
    bit pend, psof;
    logic [7:0] pd;

    tbl[0]  = '{8'd1,  1'b1, 0, 0, 8'd0, 8'd0, 1'b0};
    tbl[1]  = '{8'd2,  1'b0, 0, 1, 8'd0, 8'd0, 1'b0};
    tbl[2]  = '{8'd3,  1'b0, 0, 2, 8'd0, 8'd0, 1'b0};
    tbl[3]  = '{8'd4,  1'b0, 0, 3, 8'd0, 8'd0, 1'b0};
    tbl[4]  = '{8'd5,  1'b0, 1, 0, 8'd1, 8'd0, 1'b0};
    tbl[5]  = '{8'd6,  1'b0, 1, 1, 8'd2, 8'd0, 1'b0};
    tbl[6]  = '{8'd7,  1'b0, 1, 2, 8'd3, 8'd0, 1'b0};
    tbl[7]  = '{8'd8,  1'b0, 1, 3, 8'd4, 8'd0, 1'b0};
    tbl[8]  = '{8'd9,  1'b0, 2, 0, 8'd5, 8'd1, 1'b0};
    tbl[9]  = '{8'd10, 1'b0, 2, 1, 8'd6, 8'd2, 1'b0};
    tbl[10] = '{8'd11, 1'b0, 2, 2, 8'd7, 8'd3, 1'b1};
    tbl[11] = '{8'd12, 1'b0, 2, 3, 8'd8, 8'd4, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = 8'd0; out_ready = 1'b1;
    #1;
    reset_values("por");
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("por_in_ready", int'(in_ready), 1);

    // Pixels before any SOF are swallowed without output
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 8'(100 + i), 1'b1, acc);
      chk("pre_sof_accept", int'(acc), 1);
      @(posedge clk); #1;
      chk("pre_sof_valid", int'(out_valid), 0);
    end
    run_table("t1");

    // Back-pressure: five stalled cycles, then resume
    send(1'b1, 8'd50);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 8'd51, 1'b0, acc);
      chk("stall_in_ready", int'(in_ready), 0);
    end
    for (int i = 51; i < 56; i++) send(1'b0, 8'(i));
    drain_check("stall_drain");

    // Mid-frame restart on pixel 7
    send(1'b1, 8'd60);
    for (int i = 61; i < 66; i++) send(1'b0, 8'(i));
    send(1'b1, 8'd66);
    @(posedge clk); #1;
    chk("restart_row", int'(out_row_idx), 0);
    chk("restart_col", int'(out_col_idx), 0);
    chk("restart_c0", int'(out_col[0]), 66);
    if (BZ) chk("restart_c12", int'({out_col[2], out_col[1]}), 0);
    for (int i = 67; i < 72; i++) send(1'b0, 8'(i));
    drain_check("restart_drain");

    // Asynchronous reset during row 1
    send(1'b1, 8'd80);
    for (int i = 81; i < 86; i++) send(1'b0, 8'(i));
    @(negedge clk); in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    reset_values("midrst");
    q.delete(); m_active = 1'b0; prev_stall = 1'b0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", int'(in_ready), 1);
    run_table("t2");

    // Randomized valid/ready over a few frames, source holds a pixel until accepted
    fp = 0; pend = 1'b0; psof = 1'b0; pd = 8'd0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!pend && ($urandom_range(0, 3) != 0)) begin
        pend = 1'b1;
        pd = 8'($urandom);
        psof = (fp == 0) || ($urandom_range(0, 59) == 0);
        if (psof) fp = 0;
      end
      step(pend, psof, pd, ($urandom_range(0, 3) != 0), acc);
      if (acc) begin
        pend = 1'b0;
        fp = (fp + 1) % 24;
      end
    end
    drain_check("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
